// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row strobe, column sync, ghost-rejecting debounce FSM, 1-deep key register.
// Optional auto-repeat of a held key when KEYPAD_REPEAT_EN is defined.
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_RATE    = 10
) (
    input  logic       clk,
    input  logic       rstn,
    output logic [3:0] row_o,
    input  logic [3:0] col_i,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overflow
);

    localparam int              DIVW     = $clog2(SCAN_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [3:0]      DS       = 4'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scan: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]      col_s1, col_s2;
    logic [DIVW-1:0] div;
    logic [1:0]      row;
    logic [15:0]     map, map_nxt;
    logic            slot_end, scan_done;
    logic [4:0]      n_hits;
    logic            cand_vld;
    logic [3:0]      cand_code;

    state_t          state;
    logic [3:0]      cnt, cnt_inc, code_lat;
    logic            present, cnt_hit;
    logic            push;
    logic [3:0]      push_code;

    assign slot_end  = (div == DIV_LAST);
    assign scan_done = slot_end && (row == 2'd3);

    // The row currently being sampled is merged in so scan_done sees the whole scan.
    always_comb begin
        map_nxt = map;
        map_nxt[{row, 2'b00} +: 4] = ~col_s2;
    end

    always_comb begin
        n_hits    = '0;
        cand_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (map_nxt[i]) begin
                n_hits    = n_hits + 5'd1;
                cand_code = 4'(i);
            end
        end
        cand_vld = (n_hits == 5'd1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
            div    <= '0;
            row    <= 2'd0;
            row_o  <= 4'b1110;
            map    <= '0;
        end else begin
            col_s1 <= col_i;
            col_s2 <= col_s1;
            if (slot_end) begin
                div   <= '0;
                row   <= row + 2'd1;
                row_o <= {row_o[2:0], row_o[3]};
                map   <= map_nxt;
            end else begin
                div <= div + DIVW'(1);
            end
        end
    end

    assign present = cand_vld && (cand_code == code_lat);
    assign cnt_inc = cnt + 4'd1;
    assign cnt_hit = (cnt_inc == DS);

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] RD = 16'(REPEAT_DELAY);
    localparam logic [15:0] RR = 16'(REPEAT_RATE);

    logic [15:0] rep_cnt;
    logic        rep_first, rep_hit, enter_pressed;

    assign rep_hit = ((rep_cnt + 16'd1) == (rep_first ? RD : RR));
    assign enter_pressed = scan_done &&
        ((state == IDLE && cand_vld && DS == 4'd1) ||
         (state == DEBOUNCE && present && cnt_hit) ||
         (state == RELEASE && present));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (enter_pressed) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (scan_done && state == PRESSED && present) begin
            if (rep_hit) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        push      = 1'b0;
        push_code = code_lat;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (cand_vld && DS == 4'd1) begin
                        push      = 1'b1;
                        push_code = cand_code;
                    end
                end
                DEBOUNCE: push = present && cnt_hit;
`ifdef KEYPAD_REPEAT_EN
                PRESSED:  push = present && rep_hit;
`endif
                default:  push = 1'b0;
            endcase
        end
    end

    // key_down covers PRESSED and RELEASE: the debounced level of the key.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            code_lat <= '0;
            key_down <= 1'b0;
        end else if (scan_done) begin
            case (state)
                IDLE: begin
                    if (cand_vld) begin
                        code_lat <= cand_code;
                        cnt      <= 4'd1;
                        if (DS == 4'd1) begin
                            state    <= PRESSED;
                            key_down <= 1'b1;
                        end else begin
                            state <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (present) begin
                        cnt <= cnt_inc;
                        if (cnt_hit) begin
                            state    <= PRESSED;
                            key_down <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                PRESSED: begin
                    if (!present) begin
                        cnt <= 4'd1;
                        if (DS == 4'd1) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (present) begin
                        state <= PRESSED;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_hit) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (push) begin
            if (!key_valid || key_ready) begin
                key_code  <= push_code;
                key_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule
